// File: rtl/ssd_cmd_responder_if.sv
// Command/response and storage-backend signals of the SSD command responder.
// slave = responder side, master = command adapter plus storage backend side.
interface ssd_cmd_responder_if;
   logic [2:0]  cmd;
   logic        cmd_en;
   logic [47:0] lba;
   logic [15:0] sectorcnt;
   logic        ncq_idle;
   logic        cmd_success;
   logic        cmd_failed;
   logic        fin_read_sig;
   logic        xfer_valid;
   logic        xfer_ready;
   logic        xfer_write;
   logic [47:0] xfer_lba;
   logic [23:0] xfer_beats;
   logic        beat_done;
   logic        xfer_err;
   logic        rd_consume;

   modport slave (
      input  cmd, cmd_en, lba, sectorcnt, xfer_ready, beat_done, xfer_err, rd_consume,
      output ncq_idle, cmd_success, cmd_failed, fin_read_sig,
             xfer_valid, xfer_write, xfer_lba, xfer_beats
   );

   modport master (
      output cmd, cmd_en, lba, sectorcnt, xfer_ready, beat_done, xfer_err, rd_consume,
      input  ncq_idle, cmd_success, cmd_failed, fin_read_sig,
             xfer_valid, xfer_write, xfer_lba, xfer_beats
   );
endinterface

// File: rtl/ssd_cmd_responder.sv
// SSD-side command endpoint: validates a command, issues one backend transfer, counts beats.
// Optional XFER watchdog enabled by defining SSD_RESP_TIMEOUT_EN.
module ssd_cmd_responder #(
   parameter int          DATA_W  = 32,
   parameter logic [48:0] MAX_LBA = 49'h0_0008_0000_0000
`ifdef SSD_RESP_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES = 1048576
`endif
) (
   input logic                 clk,
   input logic                 nReset,
   ssd_cmd_responder_if.slave  io
);
   localparam logic [23:0] BEATS_PER_SECTOR = 24'(4096 / DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_XFER, S_RESP} state_t;

   state_t      r_state, w_state_next;
   logic        r_ok, w_ok_next;
   logic [2:0]  r_cmd;
   logic [47:0] r_lba;
   logic [15:0] r_sectorcnt;
   logic [23:0] r_beat_cnt;
   logic [23:0] r_rd_out, w_rd_out_next;
   logic        r_ncq_idle, r_cmd_success, r_cmd_failed, r_fin_read_sig;
   logic        r_xfer_valid, r_xfer_write;
   logic [47:0] r_xfer_lba;
   logic [23:0] r_xfer_beats;

   logic        w_is_read, w_is_write, w_range_bad, w_wdog_expired;
   logic [48:0] w_lba_end;
   logic [23:0] w_beats;

   assign w_is_read   = (r_cmd == 3'b001);
   assign w_is_write  = (r_cmd == 3'b010);
   assign w_lba_end   = {1'b0, r_lba} + {33'd0, r_sectorcnt};
   assign w_range_bad = (w_lba_end > MAX_LBA);
   assign w_beats     = {8'd0, r_sectorcnt} * BEATS_PER_SECTOR;

`ifdef SSD_RESP_TIMEOUT_EN
   logic [19:0] r_wdog;

   // Counts consecutive XFER cycles without a beat; any beat restarts the window.
   always_ff @(posedge clk) begin
      if (!nReset || r_state != S_XFER || io.beat_done)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + 20'd1;
   end

   assign w_wdog_expired = (r_state == S_XFER) && !io.beat_done &&
                           (r_wdog == 20'(TIMEOUT_CYCLES - 1));
`else
   assign w_wdog_expired = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_ok_next    = r_ok;
      case (r_state)
         S_IDLE:  if (io.cmd_en) w_state_next = S_CHECK;
         S_CHECK: begin
            if (!(w_is_read || w_is_write) || w_range_bad) begin
               w_state_next = S_RESP;
               w_ok_next    = 1'b0;
            end else if (r_sectorcnt == 16'd0) begin
               w_state_next = S_RESP;
               w_ok_next    = 1'b1;
            end else begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: if (io.xfer_ready) w_state_next = S_XFER;
         S_XFER: begin
            // A backend error outranks a final beat arriving in the same cycle.
            if (io.xfer_err) begin
               w_state_next = S_RESP;
               w_ok_next    = 1'b0;
            end else if (io.beat_done && r_beat_cnt == 24'd1) begin
               w_state_next = S_RESP;
               w_ok_next    = 1'b1;
            end else if (w_wdog_expired) begin
               w_state_next = S_RESP;
               w_ok_next    = 1'b0;
            end
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_out_next = r_rd_out;
      if (r_state == S_ISSUE && io.xfer_ready && !r_xfer_write)
         w_rd_out_next = r_xfer_beats;
      else if (r_state == S_RESP && !r_ok && w_is_read)
         w_rd_out_next = '0;
      else if (io.rd_consume && r_rd_out != 24'd0)
         w_rd_out_next = r_rd_out - 24'd1;
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         r_state        <= S_IDLE;
         r_ok           <= 1'b0;
         r_cmd          <= '0;
         r_lba          <= '0;
         r_sectorcnt    <= '0;
         r_beat_cnt     <= '0;
         r_rd_out       <= '0;
         r_ncq_idle     <= 1'b1;
         r_cmd_success  <= 1'b0;
         r_cmd_failed   <= 1'b0;
         r_fin_read_sig <= 1'b1;
         r_xfer_valid   <= 1'b0;
         r_xfer_write   <= 1'b0;
         r_xfer_lba     <= '0;
         r_xfer_beats   <= '0;
      end else begin
         r_state        <= w_state_next;
         r_ok           <= w_ok_next;
         r_ncq_idle     <= (w_state_next == S_IDLE);
         r_xfer_valid   <= (w_state_next == S_ISSUE);
         r_cmd_success  <= (r_state == S_RESP) && r_ok;
         r_cmd_failed   <= (r_state == S_RESP) && !r_ok;
         r_rd_out       <= w_rd_out_next;
         r_fin_read_sig <= (w_rd_out_next == 24'd0);
         if (r_state == S_IDLE && io.cmd_en) begin
            r_cmd       <= io.cmd;
            r_lba       <= io.lba;
            r_sectorcnt <= io.sectorcnt;
         end
         if (r_state == S_CHECK && w_state_next == S_ISSUE) begin
            r_xfer_write <= w_is_write;
            r_xfer_lba   <= r_lba;
            r_xfer_beats <= w_beats;
            r_beat_cnt   <= w_beats;
         end else if (r_state == S_XFER && io.beat_done && r_beat_cnt != 24'd0) begin
            r_beat_cnt <= r_beat_cnt - 24'd1;
         end
      end
   end

   assign io.ncq_idle     = r_ncq_idle;
   assign io.cmd_success  = r_cmd_success;
   assign io.cmd_failed   = r_cmd_failed;
   assign io.fin_read_sig = r_fin_read_sig;
   assign io.xfer_valid   = r_xfer_valid;
   assign io.xfer_write   = r_xfer_write;
   assign io.xfer_lba     = r_xfer_lba;
   assign io.xfer_beats   = r_xfer_beats;
endmodule

// File: tb/tb_ssd_cmd_responder.sv
// Scoreboard bench for ssd_cmd_responder: directed commands push expected requests/responses,
// a negedge monitor pops and compares them. Timeout case runs when SSD_RESP_TIMEOUT_EN is set.
module tb_ssd_cmd_responder;
   logic clk = 1'b0;
   logic nReset = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ssd_cmd_responder_if bus();

   ssd_cmd_responder #(
      .DATA_W(32)
`ifdef SSD_RESP_TIMEOUT_EN
      , .TIMEOUT_CYCLES(64)
`endif
   ) dut (
      .clk(clk),
      .nReset(nReset),
      .io(bus)
   );

   typedef struct { bit ok; int cyc; } resp_t;
   typedef struct { bit wr; logic [47:0] lba; logic [23:0] beats; } req_t;
   resp_t resp_q[$];
   req_t  req_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: checks every response pulse and every accepted backend request.
   always @(negedge clk) begin
      resp_t e;
      req_t  r;
      if (nReset) begin
         if (bus.cmd_success || bus.cmd_failed) begin
            if (resp_q.size() == 0) begin
               chk("unexpected_resp", {62'd0, bus.cmd_success, bus.cmd_failed}, 64'd0);
            end else begin
               e = resp_q.pop_front();
               chk("resp_kind", {62'd0, bus.cmd_success, bus.cmd_failed},
                   e.ok ? 64'd2 : 64'd1);
               if (e.cyc >= 0) chk("resp_cycle", 64'(cyc), 64'(e.cyc));
               $display("resp: success=%0b failed=%0b at cycle %0d",
                        bus.cmd_success, bus.cmd_failed, cyc);
            end
         end
         if (bus.xfer_valid && bus.xfer_ready) begin
            if (req_q.size() == 0) begin
               chk("unexpected_req", 64'd1, 64'd0);
            end else begin
               r = req_q.pop_front();
               chk("req_write", {63'd0, bus.xfer_write}, {63'd0, r.wr});
               chk("req_lba", {16'd0, bus.xfer_lba}, {16'd0, r.lba});
               chk("req_beats", {40'd0, bus.xfer_beats}, {40'd0, r.beats});
               $display("req: write=%0b lba=0x%0h beats=%0d at cycle %0d",
                        bus.xfer_write, bus.xfer_lba, bus.xfer_beats, cyc);
            end
         end else if (bus.xfer_valid && req_q.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] c, input logic [47:0] l, input logic [15:0] n);
      bus.cmd = c;
      bus.lba = l;
      bus.sectorcnt = n;
      bus.cmd_en = 1'b1;
      tick();
      bus.cmd_en = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!bus.xfer_valid && k < 50) begin
         tick();
         k++;
      end
      if (!bus.xfer_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: xfer_valid got 0 expected 1 within 50 cycles", name);
      end
   endtask

   task automatic beats(input int n, input bit err_last);
      for (int i = 0; i < n; i++) begin
         bus.beat_done = 1'b1;
         bus.xfer_err  = err_last && (i == n - 1);
         tick();
      end
      bus.beat_done = 1'b0;
      bus.xfer_err  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      bus.cmd = '0; bus.cmd_en = 1'b0; bus.lba = '0; bus.sectorcnt = '0;
      bus.xfer_ready = 1'b0; bus.beat_done = 1'b0; bus.xfer_err = 1'b0; bus.rd_consume = 1'b0;
      repeat (3) tick();
      chk("rst_ncq_idle", 64'(bus.ncq_idle), 64'd1);
      chk("rst_fin_read", 64'(bus.fin_read_sig), 64'd1);
      chk("rst_success", 64'(bus.cmd_success), 64'd0);
      chk("rst_failed", 64'(bus.cmd_failed), 64'd0);
      chk("rst_xfer_valid", 64'(bus.xfer_valid), 64'd0);
      nReset = 1'b1;
      tick();

      // Read lba 0x100, 2 sectors -> 256 beats, then 256 consumes.
      bus.xfer_ready = 1'b1;
      req_q.push_back('{1'b0, 48'h100, 24'd256});
      resp_q.push_back('{1'b1, -1});
      send_cmd(3'b001, 48'h100, 16'd2);
      chk("t1_ncq_busy", 64'(bus.ncq_idle), 64'd0);
      wait_valid("t1_valid");
      tick();
      chk("t1_fin_loaded", 64'(bus.fin_read_sig), 64'd0);
      beats(255, 1'b0);
      chk("t1_no_early_done", 64'(bus.cmd_success), 64'd0);
      beats(1, 1'b0);
      tick();
      tick();
      chk("t1_fin_pending", 64'(bus.fin_read_sig), 64'd0);
      bus.rd_consume = 1'b1;
      repeat (255) tick();
      chk("t1_fin_one_left", 64'(bus.fin_read_sig), 64'd0);
      tick();
      bus.rd_consume = 1'b0;
      chk("t1_fin_drained", 64'(bus.fin_read_sig), 64'd1);

      // Write lba 8, 1 sector, xfer_ready held off 5 cycles.
      bus.xfer_ready = 1'b0;
      req_q.push_back('{1'b1, 48'h8, 24'd128});
      resp_q.push_back('{1'b1, -1});
      send_cmd(3'b010, 48'h8, 16'd1);
      wait_valid("t2_valid");
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 64'(bus.xfer_valid), 64'd1);
         chk("t2_hold_lba", {16'd0, bus.xfer_lba}, 64'h8);
         chk("t2_hold_beats", {40'd0, bus.xfer_beats}, 64'd128);
         chk("t2_hold_write", 64'(bus.xfer_write), 64'd1);
         tick();
      end
      bus.xfer_ready = 1'b1;
      tick();
      bus.xfer_ready = 1'b0;
      chk("t2_ncq_xfer", 64'(bus.ncq_idle), 64'd0);
      beats(128, 1'b0);
      chk("t2_ncq_resp", 64'(bus.ncq_idle), 64'd0);
      chk("t2_fin_write", 64'(bus.fin_read_sig), 64'd1);
      tick();
      chk("t2_ncq_back", 64'(bus.ncq_idle), 64'd1);
      tick();
      bus.xfer_ready = 1'b1;

      // Illegal opcode and range overflow: fail 3 cycles after cmd_en, no request.
      resp_q.push_back('{1'b0, cyc + 3});
      send_cmd(3'b011, 48'h0, 16'd1);
      repeat (4) tick();
      resp_q.push_back('{1'b0, cyc + 3});
      send_cmd(3'b001, 48'h7_FFFF_FFFF, 16'd2);
      repeat (4) tick();

      // Range boundary: lba+sectorcnt == MAX_LBA is accepted.
      req_q.push_back('{1'b1, 48'h7_FFFF_FFFE, 24'd256});
      resp_q.push_back('{1'b1, -1});
      send_cmd(3'b010, 48'h7_FFFF_FFFE, 16'd2);
      wait_valid("t3_boundary_valid");
      tick();
      beats(256, 1'b0);
      repeat (2) tick();

      // Zero-sector read: immediate success, no request, fin stays 1.
      resp_q.push_back('{1'b1, cyc + 3});
      send_cmd(3'b001, 48'h40, 16'd0);
      repeat (4) tick();
      chk("t4_fin_zero", 64'(bus.fin_read_sig), 64'd1);

      // Error with the final beat; second cmd_en while busy ignored.
      req_q.push_back('{1'b0, 48'h20, 24'd128});
      resp_q.push_back('{1'b0, -1});
      send_cmd(3'b001, 48'h20, 16'd1);
      wait_valid("t5_valid");
      tick();
      chk("t5_fin_loaded", 64'(bus.fin_read_sig), 64'd0);
      beats(60, 1'b0);
      send_cmd(3'b010, 48'h999, 16'd1);
      beats(67, 1'b0);
      beats(1, 1'b1);
      tick();
      chk("t5_fin_cleared", 64'(bus.fin_read_sig), 64'd1);
      repeat (4) tick();

`ifdef SSD_RESP_TIMEOUT_EN
      // No beats: watchdog fails the command after 64 XFER cycles.
      req_q.push_back('{1'b1, 48'h50, 24'd128});
      send_cmd(3'b010, 48'h50, 16'd1);
      wait_valid("t7_valid");
      tick();
      resp_q.push_back('{1'b0, cyc + 65});
      repeat (70) tick();
`endif

      // Reset mid-XFER: everything back to reset values, no pulse.
      req_q.push_back('{1'b0, 48'h30, 24'd128});
      send_cmd(3'b001, 48'h30, 16'd1);
      wait_valid("t6_valid");
      tick();
      beats(10, 1'b0);
      nReset = 1'b0;
      repeat (2) tick();
      chk("t6_ncq_idle", 64'(bus.ncq_idle), 64'd1);
      chk("t6_success", 64'(bus.cmd_success), 64'd0);
      chk("t6_failed", 64'(bus.cmd_failed), 64'd0);
      chk("t6_fin_read", 64'(bus.fin_read_sig), 64'd1);
      chk("t6_xfer_valid", 64'(bus.xfer_valid), 64'd0);
      chk("t6_xfer_write", 64'(bus.xfer_write), 64'd0);
      chk("t6_xfer_lba", {16'd0, bus.xfer_lba}, 64'd0);
      chk("t6_xfer_beats", {40'd0, bus.xfer_beats}, 64'd0);
      nReset = 1'b1;
      repeat (5) tick();

      chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
      chk("req_queue_empty", 64'(req_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
